// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone B4 classic arbiter.
// Round-robin grant that is held for the whole cyc_i cycle of the owner.
// A watchdog turns a slave access that never completes into an err pulse
// for the owning master.
module wb_arbiter_2m #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // master 0 (cpu)
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [31:0]           m0_dat_i,
  output logic [31:0]           m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  // master 1 (dma / debug)
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [31:0]           m1_dat_i,
  output logic [31:0]           m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  // slave side
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [3:0]            s_sel_o,
  output logic [31:0]           s_dat_o,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  // observability
  output logic [1:0]            grant_o
);

  // Counter is at least one bit wide so a disabled watchdog still elaborates.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);

  // One-hot encoding so the state register doubles as the grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic           last_grant_reg;
  logic [CW-1:0]  cnt_reg;

  logic           stb_raw;
  logic           any_resp;
  logic           pending;
  logic           timeout_fire;

  assign any_resp     = s_ack_i | s_err_i | s_rty_i;
  assign pending      = s_cyc_o & stb_raw & ~any_resp;
  // Pending already excludes responses, so a simultaneous ack masks the fire.
  assign timeout_fire = WDOG_EN & pending & (cnt_reg == CNT_LAST);

  // Slave-side mux: everything follows the granted master, zero when idle.
  always_comb begin
    s_cyc_o = 1'b0;
    stb_raw = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    case (state_reg)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        stb_raw = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        stb_raw = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // The strobe is withdrawn on the watchdog cycle so the slave never sees a
  // request whose err has already been reported to the master.
  assign s_stb_o = stb_raw & ~timeout_fire;

  // Responses reach only the owner; read data is broadcast to both.
  assign m0_ack_o = s_ack_i & state_reg[0];
  assign m0_rty_o = s_rty_i & state_reg[0];
  assign m0_err_o = (s_err_i | timeout_fire) & state_reg[0];
  assign m1_ack_o = s_ack_i & state_reg[1];
  assign m1_rty_o = s_rty_i & state_reg[1];
  assign m1_err_o = (s_err_i | timeout_fire) & state_reg[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = state_reg;

  // Grant arbitration: owner keeps the bus while cyc is high, then hands
  // over directly to a waiting master; ties go to the one not served last.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last_grant_reg ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_next = GNT0;
        else if (m1_cyc_i)        state_next = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) state_next = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i) state_next = m0_cyc_i ? GNT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, round-robin history and watchdog counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == GNT0) last_grant_reg <= 1'b0;
      else if (state_next == GNT1) last_grant_reg <= 1'b1;
      if (!WDOG_EN || !pending || timeout_fire || (state_next != state_reg))
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed testbench for wb_arbiter_2m: one task per scenario, inline checks.
module tb_wb_arbiter_2m;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_w;
  logic [3:0]  m0_sel;
  logic [31:0] m0_dat_r;
  logic        m0_ack, m0_err, m0_rty;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_w;
  logic [3:0]  m1_sel;
  logic [31:0] m1_dat_r;
  logic        m1_ack, m1_err, m1_rty;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_w;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_r;
  logic        s_ack, s_err, s_rty;
  logic [1:0]  grant;

  int checks   = 0;
  int failures = 0;

  wb_arbiter_2m #(
    .TIMEOUT_CYCLES(4),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_r),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_r),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_sel_o(s_sel), .s_dat_o(s_dat_w), .s_dat_i(s_dat_r),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_w = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_w = '0;
    s_dat_r = 32'h1234_5678; s_ack = 0; s_err = 0; s_rty = 0;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++;
    if ({s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w} !== '0) begin
      failures++; $display("FAIL reset_slave_side got cyc=%b stb=%b adr=%h exp all zero", s_cyc, s_stb, s_adr);
    end
    checks++;
    if (m0_dat_r !== 32'h1234_5678) begin failures++; $display("FAIL reset_dat got=%h exp=12345678", m0_dat_r); end
    rst = 1'b0;
    #1;
    $display("reset: grant=%b s_cyc=%b", grant, s_cyc);
  endtask

  task automatic test_m0_read();
    int acks;
    acks = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h2000_0000; m0_sel = 4'hF;
    #1;
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0) begin
      failures++; $display("FAIL read_latency got grant=%b s_cyc=%b exp grant=00 s_cyc=0", grant, s_cyc);
    end
    tick();
    checks++;
    if (grant !== 2'b01 || s_adr !== 32'h2000_0000 || s_cyc !== 1'b1) begin
      failures++; $display("FAIL read_grant got grant=%b adr=%h exp grant=01 adr=20000000", grant, s_adr);
    end
    if (m0_ack) acks++;
    tick();
    if (m0_ack) acks++;
    s_ack = 1; s_dat_r = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m0_dat_r !== 32'hDEAD_BEEF || m1_ack !== 1'b0) begin
      failures++; $display("FAIL read_ack got m0_ack=%b dat=%h m1_ack=%b exp 1 deadbeef 0", m0_ack, m0_dat_r, m1_ack);
    end
    if (m0_ack) acks++;
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    if (m0_ack) acks++;
    tick();
    checks++;
    if (acks != 1 || grant !== 2'b00) begin
      failures++; $display("FAIL read_single_ack got acks=%0d grant=%b exp acks=1 grant=00", acks, grant);
    end
    $display("m0_read: acks=%0d data=%h", acks, s_dat_r);
  endtask

  task automatic test_contention();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_00A0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_00A1;
    tick();
    checks++;
    if (grant !== 2'b01 || s_adr !== 32'h0000_00A0) begin
      failures++; $display("FAIL contend_first got grant=%b adr=%h exp 01 000000a0", grant, s_adr);
    end
    s_ack = 1;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      failures++; $display("FAIL contend_ack0 got m0=%b m1=%b exp m0=1 m1=0", m0_ack, m1_ack);
    end
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    tick();
    checks++;
    if (grant !== 2'b10 || s_adr !== 32'h0000_00A1 || s_cyc !== 1'b1) begin
      failures++; $display("FAIL contend_handover got grant=%b adr=%h exp 10 000000a1", grant, s_adr);
    end
    s_ack = 1;
    #1;
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      failures++; $display("FAIL contend_ack1 got m1=%b m0=%b exp m1=1 m0=0", m1_ack, m0_ack);
    end
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    $display("contention: handover to m1 grant=%b", grant);
  endtask

  task automatic test_lock();
    m1_cyc = 1; m1_adr = 32'h0000_0B00;
    tick();
    m0_cyc = 1; m0_stb = 1;
    for (int p = 0; p < 3; p++) begin
      m1_stb = 1;
      tick();
      s_ack = 1;
      #1;
      checks++;
      if (grant !== 2'b10 || m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
        failures++; $display("FAIL lock_phase%0d got grant=%b m1_ack=%b m0_ack=%b exp 10 1 0", p, grant, m1_ack, m0_ack);
      end
      tick();
      s_ack = 0; m1_stb = 0;
      #1;
    end
    m1_cyc = 0;
    tick();
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL lock_release got grant=%b exp=01", grant); end
    m0_cyc = 0; m0_stb = 0;
    tick();
    $display("lock: m1 held 3 phases, then grant=%b", grant);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (grant !== exp) begin failures++; $display("FAIL alt_txn%0d got grant=%b exp=%b", i, grant, exp); end
      s_ack = 1;
      tick();
      s_ack = 0;
      if (exp[0]) begin m0_cyc = 0; m0_stb = 0; end
      else        begin m1_cyc = 0; m1_stb = 0; end
      tick();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      #1;
      $display("alternate: txn %0d granted=%b", i, exp);
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0C00;
    tick();
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (m0_err !== 1'b0 || s_stb !== 1'b1) begin
        failures++; $display("FAIL timeout_early%0d got err=%b stb=%b exp err=0 stb=1", c, m0_err, s_stb);
      end
      tick();
    end
    checks++;
    if (m0_err !== 1'b1 || s_stb !== 1'b0 || m1_err !== 1'b0 || grant !== 2'b01) begin
      failures++; $display("FAIL timeout_fire got err=%b stb=%b m1_err=%b grant=%b exp 1 0 0 01", m0_err, s_stb, m1_err, grant);
    end
    tick();
    checks++;
    if (m0_err !== 1'b0 || s_stb !== 1'b1 || grant !== 2'b01) begin
      failures++; $display("FAIL timeout_after got err=%b stb=%b grant=%b exp 0 1 01", m0_err, s_stb, grant);
    end
    tick(); tick(); tick();
    s_ack = 1;
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m0_err !== 1'b0 || s_stb !== 1'b1) begin
      failures++; $display("FAIL timeout_ack_wins got ack=%b err=%b stb=%b exp 1 0 1", m0_ack, m0_err, s_stb);
    end
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    $display("timeout: err pulse then ack-wins case done");
  endtask

  task automatic test_async_reset();
    m1_cyc = 1; m1_stb = 1;
    tick();
    checks++;
    if (grant !== 2'b10 || s_cyc !== 1'b1) begin
      failures++; $display("FAIL areset_pre got grant=%b s_cyc=%b exp 10 1", grant, s_cyc);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      failures++; $display("FAIL areset_immediate got grant=%b cyc=%b stb=%b exp 00 0 0", grant, s_cyc, s_stb);
    end
    m0_cyc = 1; m0_stb = 1;
    tick();
    rst = 1'b0;
    #1;
    tick();
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL areset_first got grant=%b exp=01", grant); end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();
    $display("async_reset: outputs cleared mid-cycle, m0 first after release");
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_m0_read();
    test_contention();
    test_lock();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
